// File: rtl/riscv_pkg.sv
// Shared RV32 encoding constants: opcode map and instruction-class enumeration.
// The control decoder consumes the same opcode map.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_CZ     = 7'b1111111;

    // Class codes 6 and 7 are not defined and are reported as illegal
    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_CZ     = 3'd5
    } instr_class_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock in-order FIFO. The head entry is presented combinationally so a
// word written at one edge is visible at the output in the following cycle.
// The output reads as zero whenever the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [OCC_W-1:0] occ_reg;

    logic do_push;
    logic do_pop;

    // Requests are ignored when they would overflow or underflow
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (occ_reg == OCC_W'(DEPTH));
    assign empty = (occ_reg == '0);
    assign data  = empty ? '0 : mem_reg[rd_ptr_reg];

    // Storage write; contents need no reset because the output is gated by empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); occupancy tracks push/pop
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ_reg <= occ_reg + OCC_W'(1);
                2'b01:   occ_reg <= occ_reg - OCC_W'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs an instruction class plus register/funct/immediate fields into an RV32
// instruction word and queues it for a downstream consumer. Illegal bundles are
// consumed, dropped and flagged with a one-cycle pulse.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_class,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [2:0]         in_funct3,
    input  logic [6:0]         in_funct7,
    input  logic [12:0]        in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [COUNT_W-1:0] count_o,
    output logic               illegal_o
);

    // Pure field packing; unknown classes encode as zero and are never queued
    function automatic logic [31:0] encode(
        input logic [2:0]  cls,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [12:0] imm
    );
        logic [31:0] word;
        word = '0;
        case (cls)
            CLS_R:      word = {f7, rs2, rs1, f3, rd, OP_R};
            CLS_CZ:     word = {f7, rs2, rs1, f3, rd, OP_CZ};
            CLS_I:      word = {imm[11:0], rs1, f3, rd, OP_I};
            CLS_LOAD:   word = {imm[11:0], rs1, f3, rd, OP_LOAD};
            CLS_STORE:  word = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            CLS_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, f3,
                                imm[4:1], imm[11], OP_BRANCH};
            default:    word = '0;
        endcase
        return word;
    endfunction

    // Undefined classes and misaligned branch offsets cannot be encoded
    function automatic logic is_illegal(
        input logic [2:0]  cls,
        input logic [12:0] imm
    );
        logic bad;
        bad = 1'b0;
        case (cls)
            CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_CZ: bad = 1'b0;
            CLS_BRANCH: bad = imm[0];
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

    logic               fifo_full;
    logic               fifo_empty;
    logic [31:0]        fifo_data;
    logic [31:0]        enc_word;
    logic               enc_illegal;
    logic               accept;
    logic               push;
    logic               pop;
    logic               illegal_reg;
    logic [COUNT_W-1:0] count_reg;

    assign enc_word    = encode(in_class, in_rd, in_rs1, in_rs2,
                                in_funct3, in_funct7, in_imm);
    assign enc_illegal = is_illegal(in_class, in_imm);

    // Ready depends only on FIFO occupancy and reset, never on out_ready
    assign in_ready  = !rst && !fifo_full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && !enc_illegal;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_instr = fifo_data;
    assign count_o   = count_reg;
    assign illegal_o = illegal_reg;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (rst),
        .push      (push),
        .push_data (enc_word),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .data      (fifo_data)
    );

    // One-cycle rejection pulse following each illegal accept
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_reg <= 1'b0;
        end else begin
            illegal_reg <= accept && enc_illegal;
        end
    end

    // Delivered-word counter, wraps at 2^COUNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (pop) begin
            count_reg <= count_reg + COUNT_W'(1);
        end
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Inverse of the CPU's opcode control decoder. Accepts an instruction class plus register, funct and immediate fields over a valid/ready handshake. Packs them into a 32-bit RV32 instruction word using the same opcode map the decoder consumes, and queues the words in a small FIFO for a downstream consumer such as an instruction-memory loader or test sequencer. Used to build instruction streams that exercise the single-cycle core.

## Interface
- DEPTH, 4, output FIFO entries; power of 2, ≥2
- COUNT_W, 16, width of emitted-word counter
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_class  in  3  0=R, 1=I, 2=LOAD, 3=STORE, 4=BRANCH, 5=CZ (count-zero), 6–7 illegal
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 field (R, CZ only)
- in_imm  in  13  signed immediate; I/LOAD/STORE use [11:0], BRANCH uses [12:1]
- out_valid  out  1  out_instr holds a queued word
- out_ready  in  1  consumer takes word
- out_instr  out  32  head-of-FIFO instruction word
- count_o  out  COUNT_W  words delivered (out handshakes), wraps
- illegal_o  out  1  one-cycle pulse per rejected bundle

## Operation
- **Accept:** `in_valid && in_ready` at a rising edge. Encoding is combinational on the inputs, and the word is written to the FIFO at that edge.
- **Opcodes:** R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, CZ=1111111.
- **R and CZ:** {funct7, rs2, rs1, funct3, rd, op}.
- **I and LOAD:** {imm[11:0], rs1, funct3, rd, op}. imm[12] is ignored.
- **STORE:** {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
- **BRANCH:** {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
- **Fields not used by a format:** ignored.
- **Rejection:** class 6–7, or BRANCH with imm[0]=1, is illegal. The bundle is consumed (handshake completes), nothing is queued, illegal_o=1 the next cycle, and count_o is unchanged.
- **FIFO:** in-order, DEPTH entries, occupancy counter 0..DEPTH, pointers wrap mod DEPTH.
- **count_o:** increments by 1 per `out_valid && out_ready` and wraps at 2^COUNT_W.

## Timing
- **Reset (synchronous, active-high):**
  - While rst=1: in_ready=0.
  - After the reset edge: FIFO empty, out_valid=0, out_instr=0, count_o=0, illegal_o=0.
  - From the first cycle after rst deasserts: in_ready=1.
- **Latency:** a word accepted at edge N gives out_valid=1 in the cycle after N (1 cycle).
- **in_ready** = (occupancy < DEPTH). It depends only on registered state, with no combinational path from out_ready.
- **Full:**
  - in_ready=0 even if out_ready=1 in the same cycle.
  - A pop frees a slot, and in_ready rises the next cycle.
- **Empty:** out_valid=0 and out_instr=0. A push while empty is never bypassed to the output in the same cycle.
- **Simultaneous push and pop (not full, not empty):** occupancy unchanged and both pointers advance.
- **Output stability:** while out_valid=1 and out_ready=0, out_instr holds.
- **Illegal accept with a simultaneous pop:** occupancy decrements only.
- **Reset mid-stream:** all queued words are discarded, with no partial output.

## Structure
- **Package `riscv_pkg`:**
  - OP_* opcode constants above, shared with the control decoder.
  - Class enum: CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_CZ.
- **Sub-module `sync_fifo`:**
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, full, empty, data.
  - Synchronous active-high reset.
- **Top-level logic:** the top holds the combinational encode function, the illegal detect, the illegal_o register and count_o.

## Test plan
- **R-type:** class=0, rd=3, rs1=1, rs2=2, f3=0, f7=0, out_ready=1 → out_instr=0x002081B3 one cycle after accept, count_o=1.
- **I-type, LOAD and STORE:**
  - addi class=1, rd=5, rs1=0, imm=-1 → 0xFFF00293.
  - LOAD class=2, rd=6, rs1=2, f3=2, imm=8 → 0x00812303.
  - STORE class=3, rs2=6, rs1=2, f3=2, imm=12 → 0x00612623.
- **BRANCH and CZ:**
  - BRANCH class=4, rs1=1, rs2=2, f3=0, imm=-4 → 0xFE208EE3.
  - CZ class=5, rd=1, rs1=2 → low 7 bits 0x7F.
- **Backpressure:** out_ready=0, offer 5 bundles → 4 accepted, in_ready=0. Set out_ready=1 → words emerge in order, in_ready returns the cycle after the first pop, count_o=5 at the end.
- **Illegal:** class=6, then BRANCH with imm=3 → two illegal_o pulses, FIFO stays empty, count_o unchanged.
- **Reset mid-stream:** 3 words queued, rst high for 1 cycle → out_valid=0, count_o=0. The next accept yields a fresh word with latency 1.
